// File: rtl/pong_match_ctrl_pkg.sv
// Shared types and helpers for the pong match controller: FSM states, winner codes,
// 7-segment constants, the digit table and the compare-and-subtract BCD split.
package pong_match_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SERVE_WAIT = 2'd1,
        ST_PLAY       = 2'd2,
        ST_OVER       = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        WINNER_NONE  = 2'b00,
        WINNER_LEFT  = 2'b01,
        WINNER_RIGHT = 2'b10
    } winner_t;

    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [3:0] AN_OFF    = 4'b1111;

    typedef struct packed {
        logic [3:0] tens;
        logic [3:0] units;
    } bcd_t;

    // Scores never exceed 15, so a single compare-and-subtract covers the range.
    function automatic bcd_t bcd_split(input logic [3:0] value);
        bcd_t r;
        if (value >= 4'd10) begin
            r.tens  = 4'd1;
            r.units = value - 4'd10;
        end else begin
            r.tens  = 4'd0;
            r.units = value;
        end
        return r;
    endfunction

    // Segment order {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] seg_decode(input logic [3:0] digit);
        logic [6:0] s;
        case (digit)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SEG_BLANK;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/pong_match_ctrl_seg7_scan.sv
// Four-digit multiplexed score display: free-running scan counter, BCD split,
// decode and blanking, with seg/an registered together so they never disagree.
module seg7_scan
    import pong_match_ctrl_pkg::*;
#(
    parameter int SCAN_BITS = 16
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] score_l,
    input  logic [3:0] score_r,
    input  logic       blank_l,
    input  logic       blank_r,
    output logic [6:0] seg,
    output logic [3:0] an
);

    logic [SCAN_BITS-1:0] scan_q;
    logic [1:0]           digit_idx;
    bcd_t                 bcd_l;
    bcd_t                 bcd_r;
    logic [3:0]           digit_val;
    logic                 digit_blank;
    logic [6:0]           seg_d;
    logic [3:0]           an_d;

    assign digit_idx = scan_q[SCAN_BITS-1 -: 2];

    always_comb begin
        bcd_l       = bcd_split(score_l);
        bcd_r       = bcd_split(score_r);
        digit_val   = bcd_r.units;
        digit_blank = blank_r;
        an_d        = 4'b1110;
        case (digit_idx)
            2'd0: begin
                digit_val   = bcd_r.units;
                digit_blank = blank_r;
                an_d        = 4'b1110;
            end
            2'd1: begin
                digit_val   = bcd_r.tens;
                digit_blank = blank_r || (bcd_r.tens == 4'd0);
                an_d        = 4'b1101;
            end
            2'd2: begin
                digit_val   = bcd_l.units;
                digit_blank = blank_l;
                an_d        = 4'b1011;
            end
            default: begin
                digit_val   = bcd_l.tens;
                digit_blank = blank_l || (bcd_l.tens == 4'd0);
                an_d        = 4'b0111;
            end
        endcase
        seg_d = digit_blank ? SEG_BLANK : seg_decode(digit_val);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            scan_q <= '0;
            seg    <= SEG_BLANK;
            an     <= AN_OFF;
        end else begin
            scan_q <= scan_q + SCAN_BITS'(1);
            seg    <= seg_d;
            an     <= an_d;
        end
    end

endmodule

// File: rtl/pong_match_ctrl.sv
// Match/score controller: sequences IDLE, serve delay, play and game-over,
// keeps both scores, requests ball launches and drives the score display.
module pong_match_ctrl
    import pong_match_ctrl_pkg::*;
#(
    parameter int WIN_SCORE   = 7,
    parameter int SERVE_DELAY = 65_000_000,
    parameter int SCAN_BITS   = 16,
    parameter int BLINK_BITS  = 25
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start_p,
    input  logic       point_l,
    input  logic       point_r,
    output logic       serve_req,
    output logic       serve_dir,
    output logic       play_en,
    output logic [3:0] score_l,
    output logic [3:0] score_r,
    output logic [1:0] winner,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       dp
);

    localparam int                  DLY_BITS = (SERVE_DELAY > 1) ? $clog2(SERVE_DELAY) : 1;
    localparam logic [DLY_BITS-1:0] DLY_LAST = DLY_BITS'(SERVE_DELAY - 1);
    localparam logic [3:0]          WIN      = 4'(WIN_SCORE);

    state_t                state_q, state_d;
    winner_t               winner_q, winner_d;
    logic [DLY_BITS-1:0]   dly_q, dly_d;
    logic [BLINK_BITS-1:0] blink_q;
    logic [3:0]            score_l_d, score_r_d;
    logic [3:0]            inc_l, inc_r;
    logic                  serve_dir_d, serve_req_d;
    logic                  blank_l, blank_r;

    // Saturating increments: a score already at WIN_SCORE never moves further.
    assign inc_l = (score_l < WIN) ? score_l + 4'd1 : score_l;
    assign inc_r = (score_r < WIN) ? score_r + 4'd1 : score_r;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d     = state_q;
        winner_d    = winner_q;
        dly_d       = '0;
        score_l_d   = score_l;
        score_r_d   = score_r;
        serve_dir_d = serve_dir;
        serve_req_d = 1'b0;

        case (state_q)
            ST_SERVE_WAIT: begin
                if (dly_q == DLY_LAST) begin
                    state_d     = ST_PLAY;
                    serve_req_d = 1'b1;
                end else begin
                    dly_d = dly_q + DLY_BITS'(1);
                end
            end
            ST_PLAY: begin
                if (point_l && point_r) begin
                    state_d = ST_SERVE_WAIT;
                end else if (point_l) begin
                    score_l_d = inc_l;
                    if (inc_l == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = WINNER_LEFT;
                    end else begin
                        state_d     = ST_SERVE_WAIT;
                        serve_dir_d = 1'b1;
                    end
                end else if (point_r) begin
                    score_r_d = inc_r;
                    if (inc_r == WIN) begin
                        state_d  = ST_OVER;
                        winner_d = WINNER_RIGHT;
                    end else begin
                        state_d     = ST_SERVE_WAIT;
                        serve_dir_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase

        // A start pulse restarts the match from any state and discards a coincident point.
        if (start_p) begin
            state_d     = ST_SERVE_WAIT;
            winner_d    = WINNER_NONE;
            dly_d       = '0;
            score_l_d   = 4'd0;
            score_r_d   = 4'd0;
            serve_dir_d = 1'b0;
            serve_req_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (clr) begin
            state_q   <= ST_IDLE;
            winner_q  <= WINNER_NONE;
            dly_q     <= '0;
            blink_q   <= '0;
            score_l   <= 4'd0;
            score_r   <= 4'd0;
            serve_dir <= 1'b0;
            serve_req <= 1'b0;
            play_en   <= 1'b0;
        end else begin
            state_q   <= state_d;
            winner_q  <= winner_d;
            dly_q     <= dly_d;
            blink_q   <= blink_q + BLINK_BITS'(1);
            score_l   <= score_l_d;
            score_r   <= score_r_d;
            serve_dir <= serve_dir_d;
            serve_req <= serve_req_d;
            play_en   <= (state_d == ST_PLAY);
        end
    end

    assign winner = winner_q;
    assign dp     = 1'b1;

    // Winner's digits flash in OVER while the blink MSB is low.
    assign blank_l = (state_q == ST_OVER) && (winner_q == WINNER_LEFT)  && !blink_q[BLINK_BITS-1];
    assign blank_r = (state_q == ST_OVER) && (winner_q == WINNER_RIGHT) && !blink_q[BLINK_BITS-1];

    seg7_scan #(
        .SCAN_BITS (SCAN_BITS)
    ) u_scan (
        .clk     (clk),
        .clr     (clr),
        .score_l (score_l),
        .score_r (score_r),
        .blank_l (blank_l),
        .blank_r (blank_r),
        .seg     (seg),
        .an      (an)
    );

endmodule
